bus_master_interface: RTL and testbench



---
 rtl/bus_master_interface.sv | 81 ++++++++
 tb/tb_bus_master_interface.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_master_interface.sv
// bus_master_interface: single-master initiator for the shared peripheral bus with fc handshake and timeout
module bus_master_interface #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_wr,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_mask,
    output logic        core_ready,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    output logic        rd_bus,
    output logic        wr_bus,
    output logic [3:0]  data_mask_bus,
    input  logic        fc_bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state;
    logic [15:0] cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic        wr_q, acc, fc;
    // bus pins exist only while in ACCESS; fc counts only when it is a clean 1
    always_comb begin
        acc           = state == ACCESS;
        fc            = fc_bus == 1'b1;
        core_ready    = state == IDLE;
        addr_bus      = acc ? addr_q : '0;
        data_mask_bus = acc ? mask_q : '0;
        wr_bus        = acc && wr_q;
        rd_bus        = acc && !wr_q;
    end
    assign data_bus = (acc && wr_q) ? wdata_q : 'z;
    // transaction sequencer: IDLE accepts, ACCESS waits for fc or timeout, GAP releases the bus for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state)
                IDLE: if (core_req) begin
                    addr_q  <= core_addr;
                    wdata_q <= core_wdata;
                    mask_q  <= core_mask;
                    wr_q    <= core_wr;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: if (fc) begin
                    if (!wr_q) core_rdata <= data_bus;
                    core_done <= 1'b1;
                    state     <= GAP;
                end else if (cnt == LAST) begin
                    if (!wr_q) core_rdata <= '0;
                    core_done <= 1'b1;
                    core_err  <= 1'b1;
                    state     <= GAP;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_interface.sv
// tb_bus_master_interface: directed tests against a register-file device model on the peripheral bus
module tb_bus_master_interface;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_wr = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_mask = '0;
    logic        core_ready, core_done, core_err;
    logic [31:0] core_rdata, addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus, wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;
    int          total = 0, bad = 0;
    logic [31:0] dev_ctrl = '0, dev_led = '0, force_rd = '0;
    logic        wack = 1'b0, force_fc = 1'b0;
    wire         mapped = addr_bus == 32'h0 || addr_bus == 32'h8;
    wire  [31:0] dev_q = addr_bus == 32'h8 ? dev_led : dev_ctrl;

    bus_master_interface #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_wr(core_wr),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_mask(core_mask),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err),
        .core_rdata(core_rdata), .addr_bus(addr_bus), .data_bus(data_bus),
        .rd_bus(rd_bus), .wr_bus(wr_bus), .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
    );

    always #5 clk = ~clk;

    // device: combinational read ack, registered write ack that self-clears
    assign data_bus = force_fc ? force_rd : (rd_bus && mapped) ? dev_q : 32'hz;
    assign fc_bus = force_fc | (rd_bus & mapped) | wack;
    always @(posedge clk) begin
        if (rst) wack <= 1'b0;
        else if (wr_bus && mapped && !wack) begin
            wack <= 1'b1;
            for (int i = 0; i < 4; i++)
                if (data_mask_bus[i]) begin
                    if (addr_bus == 32'h8) dev_led[8*i +: 8] <= data_bus[8*i +: 8];
                    else dev_ctrl[8*i +: 8] <= data_bus[8*i +: 8];
                end
        end else wack <= 1'b0;
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output int lat, output int acc, output logic e, output logic [31:0] rd);
        core_req = 1'b1; core_wr = w; core_addr = a; core_wdata = d; core_mask = m;
        @(negedge clk);
        core_req = 1'b0;
        lat = 1; acc = 0;
        while (!core_done && lat < 50) begin
            if (rd_bus || wr_bus) acc++;
            @(negedge clk);
            lat++;
        end
        if (!core_done) lat = -1;
        e = core_err; rd = core_rdata;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", core_ready); end
        total++; if ({core_done, core_err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b want=00", {core_done, core_err}); end
        total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", core_rdata); end
        total++; if ({rd_bus, wr_bus, data_mask_bus} !== 6'b0 || addr_bus !== 32'h0) begin bad++; $display("FAIL reset_bus got rd=%b wr=%b mask=%h addr=%h want zeros", rd_bus, wr_bus, data_mask_bus, addr_bus); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_led_write;
        int lat, acc; logic e; logic [31:0] rd;
        txn(1'b1, 32'h0, 32'h1, 4'hF, lat, acc, e, rd);
        total++; if (lat != 3) begin bad++; $display("FAIL write_latency got=%0d want=3", lat); end
        total++; if (acc != 2) begin bad++; $display("FAIL write_strobe_cycles got=%0d want=2", acc); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL write_err got=%b want=0", e); end
        total++; if (dev_ctrl !== 32'h1) begin bad++; $display("FAIL write_ctrl_en got=%h want=00000001", dev_ctrl); end
        total++; if (wr_bus !== 1'b0 || core_ready !== 1'b0) begin bad++; $display("FAIL gap_state got wr=%b ready=%b want 0 0", wr_bus, core_ready); end
        @(negedge clk);
        total++; if (core_ready !== 1'b1 || core_done !== 1'b0) begin bad++; $display("FAIL after_gap got ready=%b done=%b want 1 0", core_ready, core_done); end
    endtask

    task automatic test_write_read;
        int lat, acc; logic e; logic [31:0] rd;
        txn(1'b1, 32'h8, 32'h01000001, 4'hF, lat, acc, e, rd);
        total++; if (lat != 3) begin bad++; $display("FAIL led_write_latency got=%0d want=3", lat); end
        @(negedge clk);
        txn(1'b0, 32'h8, 32'h0, 4'hF, lat, acc, e, rd);
        total++; if (lat != 2 || acc != 1) begin bad++; $display("FAIL read_timing got lat=%0d rd_cycles=%0d want 2 1", lat, acc); end
        total++; if (rd !== 32'h01000001 || e !== 1'b0) begin bad++; $display("FAIL read_data got=%h err=%b want=01000001 0", rd, e); end
        total++; if (dev_led[0] !== 1'b1 || dev_led[24] !== 1'b1) begin bad++; $display("FAIL led_bits got=%h want led0 and led3 set", dev_led); end
        @(negedge clk);
    endtask

    task automatic test_mask;
        int lat, acc; logic e; logic [31:0] rd;
        txn(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, lat, acc, e, rd);
        total++; if (dev_ctrl !== 32'h00BB00DD) begin bad++; $display("FAIL masked_write got=%h want=00bb00dd", dev_ctrl); end
        @(negedge clk);
        txn(1'b0, 32'h0, 32'h0, 4'hF, lat, acc, e, rd);
        total++; if (rd !== 32'h00BB00DD) begin bad++; $display("FAIL masked_readback got=%h want=00bb00dd", rd); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int lat, acc; logic e; logic [31:0] rd;
        txn(1'b1, 32'h100, 32'h12345678, 4'hF, lat, acc, e, rd);
        total++; if (lat != 9 || acc != 8 || e !== 1'b1) begin bad++; $display("FAIL write_timeout got lat=%0d wr_cycles=%0d err=%b want 9 8 1", lat, acc, e); end
        total++; if (rd !== 32'h00BB00DD) begin bad++; $display("FAIL write_timeout_rdata got=%h want=00bb00dd", rd); end
        @(negedge clk);
        txn(1'b0, 32'h100, 32'h0, 4'hF, lat, acc, e, rd);
        total++; if (lat != 9 || acc != 8) begin bad++; $display("FAIL read_timeout_timing got lat=%0d rd_cycles=%0d want 9 8", lat, acc); end
        total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL read_timeout_result got err=%b rdata=%h want 1 0", e, rd); end
        total++; if (rd_bus !== 1'b0 || addr_bus !== 32'h0 || data_mask_bus !== 4'h0) begin bad++; $display("FAIL timeout_gap_bus got rd=%b addr=%h mask=%h want 0 0 0", rd_bus, addr_bus, data_mask_bus); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 32'h0; core_wdata = 32'h3; core_mask = 4'hF;
        @(negedge clk);
        total++; if (wr_bus !== 1'b1 || addr_bus !== 32'h0 || core_ready !== 1'b0) begin bad++; $display("FAIL b2b_access1 got wr=%b addr=%h ready=%b want 1 0 0", wr_bus, addr_bus, core_ready); end
        core_addr = 32'h8; core_wdata = 32'h80;
        @(negedge clk);
        total++; if (addr_bus !== 32'h0 || data_bus !== 32'h3) begin bad++; $display("FAIL b2b_ignored_req got addr=%h data=%h want 0 3", addr_bus, data_bus); end
        @(negedge clk);
        total++; if ({rd_bus, wr_bus, core_ready, core_done} !== 4'b0001) begin bad++; $display("FAIL b2b_gap got rd,wr,ready,done=%b want=0001", {rd_bus, wr_bus, core_ready, core_done}); end
        @(negedge clk);
        total++; if (core_ready !== 1'b1 || wr_bus !== 1'b0) begin bad++; $display("FAIL b2b_idle got ready=%b wr=%b want 1 0", core_ready, wr_bus); end
        @(negedge clk);
        total++; if (addr_bus !== 32'h8 || wr_bus !== 1'b1) begin bad++; $display("FAIL b2b_second got addr=%h wr=%b want 8 1", addr_bus, wr_bus); end
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (core_done !== 1'b1 || core_err !== 1'b0) begin bad++; $display("FAIL b2b_done got done=%b err=%b want 1 0", core_done, core_err); end
        total++; if (dev_ctrl !== 32'h3 || dev_led !== 32'h80) begin bad++; $display("FAIL b2b_regs got ctrl=%h led=%h want 3 80", dev_ctrl, dev_led); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 32'h8; core_wdata = 32'hDEADBEEF; core_mask = 4'hF;
        @(negedge clk);
        total++; if (wr_bus !== 1'b1) begin bad++; $display("FAIL rst_mid_access got wr=%b want 1", wr_bus); end
        rst = 1'b1; core_req = 1'b0;
        @(negedge clk);
        total++; if (wr_bus !== 1'b0 || data_bus === 32'hDEADBEEF || core_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_release got wr=%b data=%h ready=%b want 0 released 1", wr_bus, data_bus, core_ready); end
        rst = 1'b0;
        repeat (4) begin
            if (core_done) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", seen); end
        total++; if (dev_led !== 32'h80) begin bad++; $display("FAIL rst_mid_reg got=%h want=80", dev_led); end
    endtask

    task automatic test_fc_at_timeout;
        core_req = 1'b1; core_wr = 1'b0; core_addr = 32'h100; core_mask = 4'hF;
        @(negedge clk);
        core_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            total++; if (rd_bus !== 1'b1 || core_done !== 1'b0) begin bad++; $display("FAIL fc_to_access%0d got rd=%b done=%b want 1 0", k, rd_bus, core_done); end
            if (k == 8) begin force_fc = 1'b1; force_rd = 32'hCAFE0123; end
            @(negedge clk);
        end
        force_fc = 1'b0;
        total++; if (core_done !== 1'b1 || core_err !== 1'b0) begin bad++; $display("FAIL fc_wins got done=%b err=%b want 1 0", core_done, core_err); end
        total++; if (core_rdata !== 32'hCAFE0123) begin bad++; $display("FAIL fc_wins_data got=%h want=cafe0123", core_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_led_write;
        test_write_read;
        test_mask;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_fc_at_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
